// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encodings and bit-rate helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } uart_state_e;

  // Rounded to the nearest whole clock so the bit-rate error is at most half a cycle.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-time counter with restart and end-of-bit flag
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with valid/ready word input
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 57_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0
) (
  input  logic                 clk_50M,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int IW  = $clog2(DATA_BITS + 1);

  if ((CPB < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
      (STOP_BITS < 1) || (STOP_BITS > 2) || (GAP_BITS < 0) || (GAP_BITS > 15)) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 bit_end;

  assign accept = tx_valid & ready_q;

  uart_bit_timer #(.CLKS_PER_BIT(CPB)) u_timer (
    .clk_i     (clk_50M),
    .rst_ni    (reset_n),
    .restart_i (state_q == ST_IDLE),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    line_d   = line_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          shift_d  = tx_data;
          parity_d = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
          state_d  = ST_START;
          line_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = IW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_BITS)) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              line_d  = parity_q;
            end else begin
              state_d = ST_STOP;
              line_d  = 1'b1;
              cnt_d   = 4'd1;
            end
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          line_d  = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (cnt_q != 4'(STOP_BITS)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (GAP_BITS != 0) begin
            state_d = ST_GAP;
            cnt_d   = 4'd1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (cnt_q != 4'(GAP_BITS)) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Ready is registered off the next state so it rises together with tx_done.
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign serial_out = line_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign tx_ready   = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg over five parameter sets
module tb_uart_tx_cfg;

  localparam int NI = 5;
  localparam int CLKHZ [NI] = '{50_000_000, 8, 8, 8, 8};
  localparam int BAUDR [NI] = '{57_600, 2, 2, 2, 2};
  localparam int DB    [NI] = '{8, 7, 8, 8, 8};
  localparam int PAR   [NI] = '{0, 1, 2, 0, 0};
  localparam int SB    [NI] = '{1, 2, 1, 1, 1};
  localparam int GB    [NI] = '{0, 0, 0, 0, 3};
  localparam int CPB   [NI] = '{868, 4, 4, 4, 4};

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          nbits;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] tx_data    [NI];
  logic       tx_valid   [NI];
  logic       tx_ready   [NI];
  logic       busy       [NI];
  logic       tx_done    [NI];
  logic       serial_out [NI];
  logic       mon_en     [NI];

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    uart_tx_cfg #(
      .CLK_HZ    (CLKHZ[g]),
      .BAUD      (BAUDR[g]),
      .DATA_BITS (DB[g]),
      .PARITY    (PAR[g]),
      .STOP_BITS (SB[g]),
      .GAP_BITS  (GB[g])
    ) u_dut (
      .clk_50M    (clk),
      .reset_n    (reset_n),
      .tx_data    (tx_data[g][DB[g]-1:0]),
      .tx_valid   (tx_valid[g]),
      .tx_ready   (tx_ready[g]),
      .busy       (busy[g]),
      .tx_done    (tx_done[g]),
      .serial_out (serial_out[g])
    );

    initial begin : mon
      logic prev;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (mon_en[g] === 1'b1 && reset_n === 1'b1 && prev === 1'b1 && serial_out[g] === 1'b0)
          run_frame(g);
        prev = serial_out[g];
      end
    end
  end

  function automatic void chk(input int g, input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL inst=%0d %s got=%0d expected=%0d", g, name, act, exp);
    end
  endfunction

  task automatic push_exp(input int g, input logic [15:0] eb, input int n);
    exp_t e;
    e.inst  = g;
    e.bits  = eb;
    e.nbits = n;
    sb_q.push_back(e);
  endtask

  // Called at the first negedge showing the start bit; checks every cycle of the frame.
  task automatic run_frame(input int g);
    int          idx;
    int          n;
    int          cpb;
    int          bad_cyc;
    logic [15:0] eb;
    idx = -1;
    foreach (sb_q[i]) if (idx < 0 && sb_q[i].inst == g) idx = i;
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL inst=%0d unexpected_frame got=start_bit expected=idle_line", g);
      return;
    end
    eb  = sb_q[idx].bits;
    n   = sb_q[idx].nbits;
    sb_q.delete(idx);
    cpb = CPB[g];
    bad_cyc = -1;
    for (int c = 0; c < n * cpb; c++) begin
      if (c > 0) @(negedge clk);
      if (bad_cyc < 0 && (serial_out[g] !== eb[c / cpb] || busy[g] !== 1'b1 || tx_done[g] !== 1'b0))
        bad_cyc = c;
    end
    chk(g, "frame_first_bad_cycle", bad_cyc, -1);
    @(negedge clk);
    chk(g, "frame_end_done_busy_line", int'({tx_done[g], busy[g], serial_out[g]}), 3'b101);
  endtask

  task automatic send(input int g, input logic [8:0] d, input bit push, input logic [15:0] eb, input int n);
    int w;
    if (push) push_exp(g, eb, n);
    @(negedge clk);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    w = 0;
    while (tx_ready[g] !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk(g, "accept_within_bound", int'(w < 20000), 1);
    @(negedge clk);
    tx_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int w;
    w = 0;
    while (tx_ready[g] !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk(g, "idle_within_bound", int'(w < 20000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w;
    int rc;
    int s2;
    int bc;
    int left;
    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      tx_data[g]  = '0;
      tx_valid[g] = 1'b0;
      mon_en[g]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++)
      chk(g, "reset_line_busy_done_ready", int'({serial_out[g], busy[g], tx_done[g], tx_ready[g]}), 4'b1000);
    reset_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk(g, "ready_after_release", int'(tx_ready[g]), 1);
      mon_en[g] = 1'b1;
    end

    // 0x55 at defaults: 0,1,0,1,0,1,0,1,0,1
    send(0, 9'h055, 1'b1, 16'h02AA, 10);
    wait_idle(0);
    // 0x41, 7 bits even parity, 2 stops: 0,1,0,0,0,0,0,1,0,1,1
    send(1, 9'h041, 1'b1, 16'h0682, 11);
    wait_idle(1);
    // odd parity: 0x00 -> parity 1, 0x01 -> parity 0
    send(2, 9'h000, 1'b1, 16'h0600, 11);
    send(2, 9'h001, 1'b1, 16'h0402, 11);
    wait_idle(2);

    // back-to-back 0xA5 then 0x3C with valid held high
    push_exp(3, 16'h034A, 10);
    push_exp(3, 16'h0278, 10);
    @(negedge clk);
    tx_data[3]  = 9'h0A5;
    tx_valid[3] = 1'b1;
    w = 0;
    while (busy[3] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(3, "b2b_first_accept", int'(w < 100), 1);
    tx_data[3] = 9'h03C;
    rc = 0;
    s2 = -1;
    for (int c = 1; c <= 60 && s2 < 0; c++) begin
      @(negedge clk);
      if (tx_ready[3] === 1'b1) rc++;
      if (rc > 0 && serial_out[3] === 1'b0) s2 = c;
    end
    tx_valid[3] = 1'b0;
    chk(3, "b2b_ready_cycles", rc, 1);
    chk(3, "b2b_second_start_offset", s2, 41);
    wait_idle(3);

    // reset asserted during data bit 3 of an all-zero word
    mon_en[3] = 1'b0;
    send(3, 9'h000, 1'b0, 16'h0000, 0);
    repeat (17) @(negedge clk);
    chk(3, "abort_line_before_reset", int'(serial_out[3]), 0);
    #1 reset_n = 1'b0;
    #1;
    chk(3, "abort_async_line_busy_done", int'({serial_out[3], busy[3], tx_done[3]}), 3'b100);
    @(posedge clk);
    @(negedge clk);
    chk(3, "abort_ready_in_reset", int'(tx_ready[3]), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk(3, "abort_ready_after_release", int'(tx_ready[3]), 1);
    mon_en[3] = 1'b1;
    send(3, 9'h0FF, 1'b1, 16'h03FE, 10);
    wait_idle(3);

    // 0x96 with 3 gap bits; data toggled and valid pulsed while busy
    send(4, 9'h096, 1'b1, 16'h1F2C, 13);
    bc = 1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      tx_data[4]  = ~tx_data[4];
      tx_valid[4] = (c == 5 || c == 51);
      if (busy[4] === 1'b1) bc++;
    end
    tx_valid[4] = 1'b0;
    chk(4, "gap_busy_cycles", bc, 52);

    repeat (80) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      left = 0;
      foreach (sb_q[i]) if (sb_q[i].inst == g) left++;
      chk(g, "frames_outstanding", left, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog got=timeout expected=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
